// File: rtl/byte_deserializer.sv
// byte_deserializer: collects MS-first bytes into NUM_BYTES-wide words behind a one-entry valid/ready buffer
module byte_deserializer #(
  parameter int NUM_BYTES = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             inData8,
  input  logic                   inValid,
  input  logic                   inFirst,
  output logic [8*NUM_BYTES-1:0] outData64,
  output logic                   outValid,
  input  logic                   outReady,
  output logic                   alignErr,
  output logic                   overflow,
  output logic [CNT_W-1:0]       wordCount
);
  localparam int W = 8 * NUM_BYTES;
  localparam int CW = $clog2(NUM_BYTES + 1);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state;
  logic [W-1:0] shreg;
  logic [CW-1:0] cnt;
  logic take, done;
  logic [W-1:0] next_word;
  // handshake, word completion and the shifted word the current byte would produce
  always_comb begin
    take = outValid && outReady;
    done = (state == COLLECT) && inValid && !inFirst && (cnt == CW'(NUM_BYTES - 1));
    next_word = {shreg[W-9:0], inData8};
  end
  // framing FSM, shift register, output buffer and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt <= '0;
      outData64 <= '0;
      outValid <= 1'b0;
      alignErr <= 1'b0;
      overflow <= 1'b0;
      wordCount <= '0;
    end else begin
      alignErr <= 1'b0;
      if (inValid) begin
        if (inFirst) begin
          shreg <= W'(inData8);
          cnt <= CW'(1);
          state <= COLLECT;
          alignErr <= (state == COLLECT);
        end else if (state == IDLE) begin
          alignErr <= 1'b1;
        end else if (done) begin
          cnt <= '0;
          state <= IDLE;
        end else begin
          shreg <= next_word;
          cnt <= cnt + CW'(1);
        end
      end
      if (done && (!outValid || take)) begin
        outData64 <= next_word;
        outValid <= 1'b1;
      end else begin
        if (take) outValid <= 1'b0;
        if (done) overflow <= 1'b1;
      end
      if (take) wordCount <= wordCount + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_byte_deserializer.sv
// tb_byte_deserializer: directed test-plan scenarios plus randomized traffic checked against a word-level model
module tb_byte_deserializer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] inData8 = '0;
  logic inValid = 1'b0;
  logic inFirst = 1'b0;
  logic outReady = 1'b0;
  logic [63:0] outData64;
  logic outValid, alignErr, overflow;
  logic [15:0] wordCount;
  int checks = 0;
  int failures = 0;
  int errs = 0;
  logic [63:0] m_part = '0, m_buf = '0;
  int m_n = 0;
  logic m_val = 0, m_err = 0, m_ovf = 0;
  logic [15:0] m_cnt = '0;

  byte_deserializer #(.NUM_BYTES(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .inData8(inData8), .inValid(inValid), .inFirst(inFirst),
    .outData64(outData64), .outValid(outValid), .outReady(outReady),
    .alignErr(alignErr), .overflow(overflow), .wordCount(wordCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic tk, dn;
    tk = m_val && outReady;
    dn = 0;
    if (reset) begin
      m_part = '0; m_buf = '0; m_n = 0; m_val = 0; m_err = 0; m_ovf = 0; m_cnt = '0;
    end else begin
      m_err = 0;
      if (inValid) begin
        if (inFirst) begin
          m_err = (m_n > 0);
          m_part = {56'h0, inData8};
          m_n = 1;
        end else if (m_n == 0) begin
          m_err = 1;
        end else begin
          m_part = m_part * 256 + {56'h0, inData8};
          m_n++;
          if (m_n == 8) begin
            dn = 1;
            m_n = 0;
          end
        end
      end
      if (tk) m_cnt++;
      if (dn && (!m_val || tk)) begin
        m_buf = m_part;
        m_val = 1;
      end else begin
        if (dn) m_ovf = 1;
        if (tk) m_val = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("outValid", {63'h0, outValid}, {63'h0, m_val});
    chk("outData64", outData64, m_buf);
    chk("alignErr", {63'h0, alignErr}, {63'h0, m_err});
    chk("overflow", {63'h0, overflow}, {63'h0, m_ovf});
    chk("wordCount", {48'h0, wordCount}, {48'h0, m_cnt});
    if (alignErr === 1'b1) errs++;
  end

  task automatic send(input logic [7:0] b, input logic f);
    @(negedge clk);
    inValid = 1; inData8 = b; inFirst = f;
  endtask

  task automatic idle();
    @(negedge clk);
    inValid = 0; inFirst = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; inValid = 0; inFirst = 0;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int i = 7; i >= 0; i--) send(w[8*i +: 8], i == 7);
  endtask

  initial begin
    int e0, p;
    logic [63:0] g;
    do_reset();
    chk("reset_valid", {63'h0, outValid}, 64'h0);
    chk("reset_count", {48'h0, wordCount}, 64'h0);
    // continuous input
    outReady = 1;
    send_word(64'h1111111111111111);
    idle();
    chk("cont_data", outData64, 64'h1111111111111111);
    chk("cont_valid", {63'h0, outValid}, 64'h1);
    idle();
    chk("cont_valid_drop", {63'h0, outValid}, 64'h0);
    chk("cont_count", {48'h0, wordCount}, 64'h1);
    // gapped input
    do_reset();
    e0 = errs;
    g = 64'h6739293791021284;
    for (int i = 7; i >= 0; i--) begin
      send(g[8*i +: 8], i == 7);
      idle();
    end
    chk("gap_data", outData64, 64'h6739293791021284);
    chk("gap_errs", 64'(errs - e0), 64'h0);
    // misalignment
    do_reset();
    e0 = errs;
    send(8'hAA, 1); send(8'hAA, 0); send(8'hAA, 0);
    send_word(64'h2222222200222222);
    idle();
    chk("mis_data", outData64, 64'h2222222200222222);
    chk("mis_errs", 64'(errs - e0), 64'h1);
    // backpressure
    do_reset();
    outReady = 0;
    send_word(64'h4444444444444444);
    send_word(64'h0);
    idle();
    chk("bp_data", outData64, 64'h4444444444444444);
    chk("bp_valid", {63'h0, outValid}, 64'h1);
    chk("bp_ovf", {63'h0, overflow}, 64'h1);
    outReady = 1;
    idle();
    chk("bp_count", {48'h0, wordCount}, 64'h1);
    chk("bp_valid_drop", {63'h0, outValid}, 64'h0);
    chk("bp_ovf_sticky", {63'h0, overflow}, 64'h1);
    // stray bytes
    do_reset();
    e0 = errs;
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    idle(); idle();
    chk("stray_errs", 64'(errs - e0), 64'h3);
    chk("stray_valid", {63'h0, outValid}, 64'h0);
    // reset mid-word
    do_reset();
    e0 = errs;
    send(8'h55, 1); send(8'h55, 0); send(8'h55, 0); send(8'h55, 0);
    do_reset();
    send_word(64'h4444444444444444);
    idle();
    chk("rst_data", outData64, 64'h4444444444444444);
    idle();
    chk("rst_count", {48'h0, wordCount}, 64'h1);
    chk("rst_errs", 64'(errs - e0), 64'h0);
    // randomized traffic
    do_reset();
    p = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 499) == 0);
      outReady = ($urandom_range(0, 9) < 6);
      inValid = ($urandom_range(0, 9) < 7);
      inData8 = 8'($urandom);
      inFirst = (p == 0) ^ ($urandom_range(0, 19) == 0);
      if (inValid) p = (p + 1) % 8;
    end
    do_reset();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
